// File: rtl/buffered_serializer.sv
// buffered_serializer
// Captures a wide input word into a local register and emits it as
// ceil(NIN/NOUT) narrow beats. Each beat carries a last flag in its MSB.
// The upstream channel is released as soon as the word is captured. A new
// word can be taken on the same edge that the last beat leaves, so
// back-to-back words stream without a bubble.
module buffered_serializer #(
    parameter int NIN       = 32,
    parameter int NOUT      = 8,
    parameter int MSB_FIRST = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_v,
    output logic            in_a,
    input  logic [NIN-1:0]  in_d,
    output logic            out_v,
    input  logic            out_a,
    output logic [NOUT:0]   out_d,
    output logic            busy
);

    // Beat count, beat-index width and padded word width
    localparam int D  = (NIN + NOUT - 1) / NOUT;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int WW = D * NOUT;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WW-1:0]   r_word;
    logic [WW-1:0]   w_word_nxt;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;

    logic            w_full;
    logic            w_last;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic [IW-1:0]   w_sel;
    logic [WW-1:0]   w_shifted;
    logic [NOUT-1:0] w_payload;
    logic [WW-1:0]   w_in_pad;

    // Handshake decode: a new word is accepted when empty, or when the
    // final beat is leaving on this edge.
    always_comb begin
        w_full     = (r_state == S_FULL);
        w_last     = (r_idx == IW'(D - 1));
        in_a       = ~w_full | (out_a & w_full & w_last);
        w_in_xfer  = in_v & in_a;
        w_out_xfer = w_full & out_a;
        w_in_pad   = WW'(in_d);
    end

    // Chunk selection: the beat counter always runs upward; the order is
    // applied here by mirroring the chunk index.
    always_comb begin
        w_sel = r_idx;
        if (MSB_FIRST != 0) begin
            w_sel = IW'(D - 1) - r_idx;
        end
        w_shifted = r_word >> (NOUT * int'(w_sel));
        w_payload = w_shifted[NOUT-1:0];
    end

    // Output drive: the data bus is forced to zero while nothing is held,
    // so a stale word never appears on the bus.
    always_comb begin
        out_v = w_full;
        busy  = w_full;
        out_d = '0;
        if (w_full) begin
            out_d = {w_last, w_payload};
        end
    end

    // Next-state logic: a capture takes priority because it can only
    // coincide with the last beat leaving; otherwise a beat transfer
    // advances the counter or empties the register on the final beat.
    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_idx_nxt   = r_idx;
        if (w_in_xfer) begin
            w_state_nxt = S_FULL;
            w_word_nxt  = w_in_pad;
            w_idx_nxt   = '0;
        end else if (w_out_xfer) begin
            if (w_last) begin
                w_state_nxt = S_EMPTY;
                w_idx_nxt   = '0;
            end else begin
                w_idx_nxt   = r_idx + IW'(1);
            end
        end
    end

    // State register. An asynchronous reset discards any word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_EMPTY;
            r_word  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

endmodule

// File: tb/tb_buffered_serializer.sv
// Testbench for buffered_serializer: three instances (32/8 LSB-first,
// 20/8 MSB-first, 8/8 single beat) with scoreboard queues per instance.
module tb_buffered_serializer;

    logic clk;
    logic reset;

    logic        a_in_v, a_in_a, a_out_v, a_out_a, a_busy;
    logic [31:0] a_in_d;
    logic [8:0]  a_out_d;

    logic        b_in_v, b_in_a, b_out_v, b_out_a, b_busy;
    logic [19:0] b_in_d;
    logic [8:0]  b_out_d;

    logic        c_in_v, c_in_a, c_out_v, c_out_a, c_busy;
    logic [7:0]  c_in_d;
    logic [8:0]  c_out_d;

    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [8:0] qc[$];

    int n_total;
    int n_bad;

    buffered_serializer #(.NIN(32), .NOUT(8), .MSB_FIRST(0)) u_a (
        .clk(clk), .reset(reset),
        .in_v(a_in_v), .in_a(a_in_a), .in_d(a_in_d),
        .out_v(a_out_v), .out_a(a_out_a), .out_d(a_out_d),
        .busy(a_busy)
    );

    buffered_serializer #(.NIN(20), .NOUT(8), .MSB_FIRST(1)) u_b (
        .clk(clk), .reset(reset),
        .in_v(b_in_v), .in_a(b_in_a), .in_d(b_in_d),
        .out_v(b_out_v), .out_a(b_out_a), .out_d(b_out_d),
        .busy(b_busy)
    );

    buffered_serializer #(.NIN(8), .NOUT(8), .MSB_FIRST(0)) u_c (
        .clk(clk), .reset(reset),
        .in_v(c_in_v), .in_a(c_in_a), .in_d(c_in_d),
        .out_v(c_out_v), .out_a(c_out_a), .out_d(c_out_d),
        .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            qa.push_back({(k == 3), w[8*k +: 8]});
        end
    endtask

    // Scoreboard monitors: every beat that transfers is popped and compared
    always @(negedge clk) begin
        if (reset && a_out_v && a_out_a) begin
            if (qa.size() == 0) check("A_extra_beat", 32'(qa.size()), 1);
            else check("A_beat", {23'd0, a_out_d}, {23'd0, qa.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (reset && b_out_v && b_out_a) begin
            if (qb.size() == 0) check("B_extra_beat", 32'(qb.size()), 1);
            else check("B_beat", {23'd0, b_out_d}, {23'd0, qb.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (reset && c_out_v && c_out_a) begin
            if (qc.size() == 0) check("C_extra_beat", 32'(qc.size()), 1);
            else check("C_beat", {23'd0, c_out_d}, {23'd0, qc.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b0;
        a_in_v = 0; a_in_d = '0; a_out_a = 1;
        b_in_v = 0; b_in_d = '0; b_out_a = 1;
        c_in_v = 0; c_in_d = '0; c_out_a = 1;

        // Reset state
        #3;
        check("rst_A_out_v", a_out_v, 0);
        check("rst_A_busy", a_busy, 0);
        check("rst_A_in_a", a_in_a, 1);
        check("rst_A_out_d", a_out_d, 0);
        check("rst_B_in_a", b_in_a, 1);
        check("rst_C_out_v", c_out_v, 0);
        #9;
        reset = 1'b1;
        tick();

        // Single word, LSB first, no backpressure
        check("t1_idle_in_a", a_in_a, 1);
        a_in_v = 1; a_in_d = 32'hAABBCCDD;
        push_a(32'hAABBCCDD);
        tick();
        a_in_v = 0;
        for (int t = 0; t < 4; t++) begin
            check("t1_out_v", a_out_v, 1);
            check("t1_busy", a_busy, 1);
            tick();
        end
        check("t1_done_out_v", a_out_v, 0);
        check("t1_done_in_a", a_in_a, 1);

        // Two words back to back, no idle cycle
        check("t2_idle_in_a", a_in_a, 1);
        a_in_v = 1; a_in_d = 32'h11223344;
        push_a(32'h11223344);
        tick();
        a_in_d = 32'h55667788;
        push_a(32'h55667788);
        for (int t = 0; t < 8; t++) begin
            check("t2_out_v", a_out_v, 1);
            check("t2_in_a", a_in_a, ((t % 4) == 3) ? 1 : 0);
            if (t == 4) check("t2_second_first", {23'd0, a_out_d}, 32'h088);
            tick();
            if (t == 3) a_in_v = 0;
        end
        check("t2_done_out_v", a_out_v, 0);

        // Backpressure on the third beat
        a_in_v = 1; a_in_d = 32'hAABBCCDD;
        push_a(32'hAABBCCDD);
        tick();
        a_in_v = 0;
        tick();
        tick();
        a_out_a = 0;
        for (int t = 0; t < 3; t++) begin
            check("t3_hold_d", {23'd0, a_out_d}, 32'h0BB);
            check("t3_hold_v", a_out_v, 1);
            check("t3_hold_in_a", a_in_a, 0);
            tick();
        end
        a_out_a = 1;
        check("t3_resume_d", {23'd0, a_out_d}, 32'h0BB);
        tick();
        check("t3_last_d", {23'd0, a_out_d}, 32'h1AA);
        check("t3_last_in_a", a_in_a, 1);
        tick();
        check("t3_done_out_v", a_out_v, 0);

        // 20-bit word, MSB first, top chunk zero-padded
        b_in_v = 1; b_in_d = 20'hABCDE;
        qb.push_back(9'h00A);
        qb.push_back(9'h0BC);
        qb.push_back(9'h1DE);
        tick();
        b_in_v = 0;
        check("t4_first_d", {23'd0, b_out_d}, 32'h00A);
        tick();
        tick();
        check("t4_last_d", {23'd0, b_out_d}, 32'h1DE);
        tick();
        check("t4_done_out_v", b_out_v, 0);

        // Asynchronous reset mid-word
        a_in_v = 1; a_in_d = 32'hAABBCCDD;
        push_a(32'hAABBCCDD);
        tick();
        a_in_v = 0;
        tick();
        check("t5_pre_rst_d", {23'd0, a_out_d}, 32'h0CC);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_out_v", a_out_v, 0);
        check("t5_rst_busy", a_busy, 0);
        check("t5_rst_in_a", a_in_a, 1);
        check("t5_rst_out_d", {23'd0, a_out_d}, 0);
        qa.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("t5_post_out_v", a_out_v, 0);
        a_in_v = 1; a_in_d = 32'h01020304;
        push_a(32'h01020304);
        tick();
        a_in_v = 0;
        check("t5_first_d", {23'd0, a_out_d}, 32'h004);
        for (int t = 0; t < 4; t++) tick();
        check("t5_done_out_v", a_out_v, 0);

        // Single-beat configuration at full throughput
        c_in_v = 1; c_in_d = 8'h01;
        qc.push_back(9'h101);
        check("t6_in_a0", c_in_a, 1);
        tick();
        c_in_d = 8'h02;
        qc.push_back(9'h102);
        check("t6_d1", {23'd0, c_out_d}, 32'h101);
        check("t6_in_a1", c_in_a, 1);
        tick();
        c_in_d = 8'h03;
        qc.push_back(9'h103);
        check("t6_d2", {23'd0, c_out_d}, 32'h102);
        check("t6_in_a2", c_in_a, 1);
        tick();
        c_in_v = 0;
        check("t6_d3", {23'd0, c_out_d}, 32'h103);
        check("t6_in_a3", c_in_a, 1);
        tick();
        check("t6_done_out_v", c_out_v, 0);

        // All expected beats consumed
        tick();
        check("A_q_empty", 32'(qa.size()), 0);
        check("B_q_empty", 32'(qb.size()), 0);
        check("C_q_empty", 32'(qc.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
